bl_order_gen_mp: RTL

- Parametrised successor to the single-pol baseline order generator.
- Tracks the X-engine output stream (sync_out/vld_out of the xeng top) and labels every valid output word with its antenna pair, tap, Stokes index, redundancy flag and window framing.
- Adds multi-Stokes ordering, window counting and an MCNT tag.
- Feeds the downstream packetiser and the bench scoreboards.

---
 rtl/bl_order_gen_mp_pkg.sv | 31 +++
 rtl/bl_order_gen_mp_if.sv | 45 ++++
 rtl/bl_order_gen_mp_cnt.sv | 53 +++++
 rtl/bl_order_gen_mp.sv | 109 ++++++++++
 4 files changed

// File: rtl/bl_order_gen_mp_pkg.sv
// Shared types and sizing helpers for the baseline order generator.
package xeng_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WAIT = 2'd2} state_t;

  function automatic int log2c(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int n_taps(input int n_ants);
    return n_ants / 2 + 1;
  endfunction

  function automatic int win_len(input int n_ants, input int n_stokes);
    return n_taps(n_ants) * n_ants * n_stokes;
  endfunction

  function automatic int stk_bits(input int n_stokes);
    return (log2c(n_stokes) < 1) ? 1 : log2c(n_stokes);
  endfunction

  localparam int DEF_N_ANTS   = 10;
  localparam int DEF_N_STOKES = 1;
  localparam int N_TAPS       = n_taps(DEF_N_ANTS);
  localparam int WIN_LEN      = win_len(DEF_N_ANTS, DEF_N_STOKES);

endpackage

// File: rtl/bl_order_gen_mp_if.sv
// Stream-in / label-out bundle for bl_order_gen_mp. Optional bl_idx under BL_ORDER_FLAT_IDX_EN.
interface bl_order_gen_mp_if #(
  parameter int N_ANTS        = 10,
  parameter int N_STOKES      = 1,
  parameter int MCNT_WIDTH    = 48,
  parameter int WIN_CNT_WIDTH = 16
);
  localparam int ANT_BITS = xeng_pkg::log2c(N_ANTS);
  localparam int TAP_BITS = xeng_pkg::log2c(xeng_pkg::n_taps(N_ANTS));
  localparam int STK_BITS = xeng_pkg::stk_bits(N_STOKES);
  localparam int IDX_BITS = xeng_pkg::log2c(xeng_pkg::n_taps(N_ANTS) * N_ANTS);

  logic                     sync;
  logic                     en;
  logic [MCNT_WIDTH-1:0]    mcnt_in;
  logic [ANT_BITS-1:0]      ant_a;
  logic [ANT_BITS-1:0]      ant_b;
  logic [TAP_BITS-1:0]      tap;
  logic [STK_BITS-1:0]      stokes;
  logic                     redundant;
  logic                     first;
  logic                     last;
  logic                     out_vld;
  logic [MCNT_WIDTH-1:0]    mcnt_out;
  logic [WIN_CNT_WIDTH-1:0] win_cnt;
`ifdef BL_ORDER_FLAT_IDX_EN
  logic [IDX_BITS-1:0]      bl_idx;
`endif

  modport master (
    output sync, en, mcnt_in,
    input  ant_a, ant_b, tap, stokes, redundant, first, last, out_vld, mcnt_out, win_cnt
`ifdef BL_ORDER_FLAT_IDX_EN
    , input bl_idx
`endif
  );

  modport slave (
    input  sync, en, mcnt_in,
    output ant_a, ant_b, tap, stokes, redundant, first, last, out_vld, mcnt_out, win_cnt
`ifdef BL_ORDER_FLAT_IDX_EN
    , output bl_idx
`endif
  );
endinterface

// File: rtl/bl_order_gen_mp_cnt.sv
// Three-level wrap counter (stokes innermost, then antenna, then tap).
// Outputs show the effective current element: zero while clr is high.
module bl_nested_cnt #(
  parameter int N_STOKES = 1,
  parameter int N_ANTS   = 10,
  parameter int N_TAPS   = 6,
  parameter int STK_BITS = 1,
  parameter int ANT_BITS = 4,
  parameter int TAP_BITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                inc,
  output logic [STK_BITS-1:0] stk,
  output logic [ANT_BITS-1:0] ant,
  output logic [TAP_BITS-1:0] tap,
  output logic                tc
);
  logic [STK_BITS-1:0] stk_q;
  logic [ANT_BITS-1:0] ant_q;
  logic [TAP_BITS-1:0] tap_q;
  logic stk_last, ant_last, tap_last;

  assign stk      = clr ? '0 : stk_q;
  assign ant      = clr ? '0 : ant_q;
  assign tap      = clr ? '0 : tap_q;
  assign stk_last = (stk == STK_BITS'(N_STOKES - 1));
  assign ant_last = (ant == ANT_BITS'(N_ANTS - 1));
  assign tap_last = (tap == TAP_BITS'(N_TAPS - 1));
  assign tc       = stk_last && ant_last && tap_last;

  // Increment is applied on top of the cleared value, so clr+inc lands on element 1.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stk_q <= '0;
      ant_q <= '0;
      tap_q <= '0;
    end else if (inc) begin
      stk_q <= stk_last ? '0 : stk + 1'b1;
      if (stk_last) begin
        ant_q <= ant_last ? '0 : ant + 1'b1;
        tap_q <= ant_last ? (tap_last ? '0 : tap + 1'b1) : tap;
      end else begin
        ant_q <= ant;
        tap_q <= tap;
      end
    end else if (clr) begin
      stk_q <= '0;
      ant_q <= '0;
      tap_q <= '0;
    end
endmodule

// File: rtl/bl_order_gen_mp.sv
// Labels each valid xeng output word with baseline, tap, Stokes and window framing.
// Optional flat baseline index output enabled by BL_ORDER_FLAT_IDX_EN.
module bl_order_gen_mp
  import xeng_pkg::*;
#(
  parameter int N_ANTS        = 10,
  parameter int N_STOKES      = 1,
  parameter int MCNT_WIDTH    = 48,
  parameter int WIN_CNT_WIDTH = 16
) (
  input logic            clk,
  input logic            rst_n,
  bl_order_gen_mp_if.slave bus
);
  localparam int NT       = n_taps(N_ANTS);
  localparam int ANT_BITS = log2c(N_ANTS);
  localparam int TAP_BITS = log2c(NT);
  localparam int STK_BITS = stk_bits(N_STOKES);

  state_t state;
  logic [STK_BITS-1:0] stk;
  logic [ANT_BITS-1:0] ant;
  logic [TAP_BITS-1:0] tap;
  logic                tc;
  logic                issue;
  logic [ANT_BITS:0]   sum;
  logic [ANT_BITS-1:0] ant_b_nx;
  logic                red_nx;
  logic                first_nx;

  assign issue = bus.en && (bus.sync || state == RUN);

  bl_nested_cnt #(
    .N_STOKES(N_STOKES), .N_ANTS(N_ANTS), .N_TAPS(NT),
    .STK_BITS(STK_BITS), .ANT_BITS(ANT_BITS), .TAP_BITS(TAP_BITS)
  ) u_cnt (
    .clk(clk), .rst_n(rst_n), .clr(bus.sync), .inc(issue),
    .stk(stk), .ant(ant), .tap(tap), .tc(tc)
  );

  // a + t < 2*N_ANTS, so a single conditional subtract gives the modulus.
  assign sum      = (ANT_BITS+1)'(ant) + (ANT_BITS+1)'(tap);
  assign ant_b_nx = (sum >= (ANT_BITS+1)'(N_ANTS)) ? ANT_BITS'(sum - (ANT_BITS+1)'(N_ANTS))
                                                  : ANT_BITS'(sum);
  assign red_nx   = (N_ANTS % 2 == 0) && (tap == TAP_BITS'(NT - 1)) &&
                    (ant >= ANT_BITS'(N_ANTS / 2));
  assign first_nx = (stk == '0) && (ant == '0) && (tap == '0);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      bus.ant_a     <= '0;
      bus.ant_b     <= '0;
      bus.tap       <= '0;
      bus.stokes    <= '0;
      bus.redundant <= 1'b0;
      bus.first     <= 1'b0;
      bus.last      <= 1'b0;
      bus.out_vld   <= 1'b0;
      bus.mcnt_out  <= '0;
      bus.win_cnt   <= '0;
    end else begin
      if (bus.sync) begin
        state        <= RUN;
        bus.mcnt_out <= bus.mcnt_in;
      end
      if (issue) begin
        bus.ant_a     <= ant;
        bus.ant_b     <= ant_b_nx;
        bus.tap       <= tap;
        bus.stokes    <= stk;
        bus.redundant <= red_nx;
        bus.first     <= first_nx;
        bus.last      <= tc;
        bus.out_vld   <= 1'b1;
        // tc is never set alongside sync, so a restart cannot close a window.
        if (tc) begin
          state       <= WAIT;
          bus.win_cnt <= bus.win_cnt + 1'b1;
        end
      end else begin
        bus.out_vld <= 1'b0;
      end
    end

`ifdef BL_ORDER_FLAT_IDX_EN
  localparam int IDX_BITS = log2c(NT * N_ANTS);
  logic [IDX_BITS-1:0] flat_q;
  logic [IDX_BITS-1:0] flat;

  assign flat = bus.sync ? '0 : flat_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      flat_q     <= '0;
      bus.bl_idx <= '0;
    end else if (issue) begin
      bus.bl_idx <= flat;
      if (tc)
        flat_q <= '0;
      else if (stk == STK_BITS'(N_STOKES - 1))
        flat_q <= flat + 1'b1;
      else
        flat_q <= flat;
    end else if (bus.sync) begin
      flat_q <= '0;
    end
`endif
endmodule
